// File: rtl/tile_palette_decoder.sv
// Tile palette decoder: maps (tile level, glyph pixel index) to RGB through a shared
// palette table, with a two-stage pipeline and a merge-flash brightening effect.
// Optional feature macro: PALETTE_WR_EN. When defined, the palette is a writable register
// array; otherwise it is a constant ROM of the default colours.
module tile_palette_decoder #(
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned NUM_LEVELS   = 12,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter logic [COLOR_W-1:0] ERR_COLOR = 'hF0F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [LEVEL_W-1:0] in_level,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic               wr_en,
  input  logic [LEVEL_W-1:0] wr_level,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               flash_start,
  input  logic [LEVEL_W-1:0] flash_level,
  input  logic               frame_tick,
  output logic [COLOR_W-1:0] pixel,
  output logic               out_valid,
  output logic               flash_active
);

  localparam int unsigned NUM_IDX = 2 ** IDX_W;
  localparam int unsigned TBL_W   = NUM_LEVELS * NUM_IDX * COLOR_W;
  localparam int unsigned CH_W    = COLOR_W / 3;
  localparam logic [CH_W:0] CH_TOP = (CH_W + 1)'(2 ** CH_W);  // cmax + 1

  // Default 2048 colours; idx2/3 repeat idx0 except the empty-grid level.
  function automatic logic [11:0] default_color12(input int unsigned lvl, input int unsigned idx);
    logic [11:0] c0, c1;
    c0 = 12'h000;
    c1 = 12'hFFF;
    case (lvl)
      0:  begin c0 = 12'hFFE; c1 = 12'hBA9; end
      1:  begin c0 = 12'hEED; c1 = 12'h000; end
      2:  begin c0 = 12'hEDC; c1 = 12'h000; end
      3:  c0 = 12'hFB7;
      4:  c0 = 12'hF96;
      5:  c0 = 12'hF75;
      6:  c0 = 12'hF53;
      7:  c0 = 12'hEC7;
      8:  c0 = 12'hEC6;
      9:  c0 = 12'hEC5;
      10: c0 = 12'hEC3;
      11: c0 = 12'hEC2;
      default: begin c0 = 12'h000; c1 = 12'h000; end
    endcase
    if (lvl == 0 && idx == 2) return 12'hCCB;
    return (idx == 1) ? c1 : c0;
  endfunction

  function automatic logic [TBL_W-1:0] default_table();
    logic [TBL_W-1:0] t;
    t = '0;
    for (int unsigned l = 0; l < NUM_LEVELS; l++) begin
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
        t[(l * NUM_IDX + i) * COLOR_W +: COLOR_W] = COLOR_W'(default_color12(l, i));
      end
    end
    return t;
  endfunction

  // Brighten each channel halfway toward full scale, computed one bit wider.
  function automatic logic [COLOR_W-1:0] blend(input logic [COLOR_W-1:0] c);
    logic [COLOR_W-1:0] r;
    logic [CH_W:0]      ch;
    r = c;
    for (int unsigned k = 0; k < 3; k++) begin
      ch = ({1'b0, c[k * CH_W +: CH_W]} + CH_TOP) >> 1;
      r[k * CH_W +: CH_W] = ch[CH_W-1:0];
    end
    return r;
  endfunction

  localparam logic [TBL_W-1:0] DEFAULT_TBL = default_table();

  typedef enum logic [0:0] {StIdle, StFlash} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;

  logic               s1_valid_q, s1_oor_q;
  logic [LEVEL_W-1:0] s1_level_q;
  logic [COLOR_W-1:0] s1_color_q;

  logic [TBL_W-1:0]   tbl;
  logic               in_range;
  int unsigned        rd_off;
  logic [COLOR_W-1:0] rd_color;

  assign in_range = 32'(in_level) < NUM_LEVELS;
  assign rd_off   = in_range ? (32'(in_level) * NUM_IDX + 32'(in_idx)) * COLOR_W : 0;
  assign rd_color = in_range ? tbl[rd_off +: COLOR_W] : ERR_COLOR;

`ifdef PALETTE_WR_EN
  logic [TBL_W-1:0] tbl_q;
  logic             wr_ok;
  int unsigned      wr_off;

  assign wr_ok  = wr_en && (32'(wr_level) < NUM_LEVELS);
  assign wr_off = wr_ok ? (32'(wr_level) * NUM_IDX + 32'(wr_idx)) * COLOR_W : 0;
  assign tbl    = tbl_q;

  // Palette register array; a same-cycle read sees the old entry since S1 samples it here too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_q <= DEFAULT_TBL;
    end else if (wr_ok) begin
      tbl_q[wr_off +: COLOR_W] <= wr_data;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_level, wr_idx, wr_data};
  assign tbl       = DEFAULT_TBL;
`endif

  // S1: capture request and the table entry it addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_level_q <= '0;
      s1_color_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_oor_q   <= !in_range;
        s1_level_q <= in_level;
        s1_color_q <= rd_color;
      end
    end
  end

  // S2: apply flash using the FSM state of this cycle; pixel holds when nothing is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pixel     <= '0;
    end else begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        if (state_q == StFlash && !s1_oor_q && s1_level_q == lvl_q) begin
          pixel <= blend(s1_color_q);
        end else begin
          pixel <= s1_color_q;
        end
      end
    end
  end

  // Flash FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  // Flash FSM next state: a start (re)loads the full count and wins over a frame tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      StIdle: begin
        if (flash_start) begin
          state_d = StFlash;
          cnt_d   = 8'(FLASH_FRAMES);
          lvl_d   = flash_level;
        end
      end
      StFlash: begin
        if (flash_start) begin
          cnt_d = 8'(FLASH_FRAMES);
          lvl_d = flash_level;
        end else if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign flash_active = (state_q == StFlash);

endmodule

// File: tb/tb_tile_palette_decoder.sv
// Self-checking bench for tile_palette_decoder: expected pixels are queued at drive time
// from a reference palette/flash model and popped when out_valid appears.
module tb_tile_palette_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_level = '0;
  logic [1:0]  in_idx = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_level = '0;
  logic [1:0]  wr_idx = '0;
  logic [11:0] wr_data = '0;
  logic        flash_start = 1'b0;
  logic [3:0]  flash_level = '0;
  logic        frame_tick = 1'b0;
  logic [11:0] pixel;
  logic        out_valid;
  logic        flash_active;

  always #5 clk = ~clk;

  tile_palette_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_level     (in_level),
    .in_idx       (in_idx),
    .wr_en        (wr_en),
    .wr_level     (wr_level),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .flash_start  (flash_start),
    .flash_level  (flash_level),
    .frame_tick   (frame_tick),
    .pixel        (pixel),
    .out_valid    (out_valid),
    .flash_active (flash_active)
  );

  logic [11:0] exp_q[$];
  logic [11:0] pal [16][4];
  bit          m_active;
  int          m_lvl;
  int          m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] last_pix = '0;
  int          n_out = 0;
  int          run_len = 0;
  int          max_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_defaults();
    logic [11:0] c0 [12] = '{12'hFFE, 12'hEED, 12'hEDC, 12'hFB7, 12'hF96, 12'hF75,
                             12'hF53, 12'hEC7, 12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2};
    for (int l = 0; l < 16; l++) begin
      for (int i = 0; i < 4; i++) pal[l][i] = (l < 12) ? c0[l] : 12'h000;
      if (l >= 3 && l < 12) pal[l][1] = 12'hFFF;
    end
    pal[0][1] = 12'hBA9;
    pal[0][2] = 12'hCCB;
    pal[1][1] = 12'h000;
    pal[2][1] = 12'h000;
  endtask

  function automatic logic [11:0] brighten(input logic [11:0] c);
    logic [11:0] r;
    for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((c[k*4 +: 4] >> 1) + 8);
    return r;
  endfunction

  function automatic logic [11:0] model(input int lvl, input int idx);
    logic [11:0] c;
    if (lvl >= 12) return 12'hF0F;
    c = pal[lvl][idx];
    if (m_active && lvl == m_lvl) c = brighten(c);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int lvl, input int idx);
    in_valid = 1'b1;
    in_level = 4'(lvl);
    in_idx   = 2'(idx);
    exp_q.push_back(model(lvl, idx));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    exp_q.delete();
    m_active = 0;
    m_cnt    = 0;
    last_pix = '0;
    load_defaults();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_flash(input int lvl, input bit with_tick);
    flash_start = 1'b1;
    flash_level = 4'(lvl);
    frame_tick  = with_tick;
    step();
    flash_start = 1'b0;
    frame_tick  = 1'b0;
    m_active = 1;
    m_lvl    = lvl;
    m_cnt    = 8;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (m_active) begin
      m_cnt--;
      if (m_cnt == 0) m_active = 0;
    end
  endtask

  // Output monitor: pop and compare on valid, check hold and contiguity otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("spurious_valid", out_valid, 1'b0);
        else check_eq("pixel", pixel, exp_q.pop_front());
        last_pix = pixel;
        n_out++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
        if (n_out > 0) check_eq("pixel_hold", pixel, last_pix);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    load_defaults();
    #1 rst = 1'b1;
    #2;
    check_eq("rst_pixel", pixel, 12'h000);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_flash", flash_active, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Latency 2: nothing one cycle after the request, valid two cycles after.
    lookup(3, 0);
    check_eq("lat1_valid", out_valid, 1'b0);
    step();
    check_eq("lat2_valid", out_valid, 1'b1);
    lookup(3, 1);
    drain();

    // Back-to-back stream of all levels.
    max_run = 0;
    for (int l = 0; l < 12; l++) lookup(l, 1);
    drain();
    check_eq("stream_run", max_run, 12);
    for (int i = 0; i < 4; i++) lookup(0, i);
    lookup(2, 3);
    drain();

    // Out-of-range level, including while it is the flashed level.
    lookup(13, 0);
    drain();
    pulse_flash(13, 0);
    check_eq("flash_oor_active", flash_active, 1'b1);
    lookup(13, 1);
    lookup(4, 0);
    drain();

    // Same-cycle write returns old data, next cycle sees new data, reset restores.
    wr_en = 1'b1; wr_level = 4'd1; wr_idx = 2'd0; wr_data = 12'h123;
    lookup(1, 0);
    wr_en = 1'b0;
`ifdef PALETTE_WR_EN
    pal[1][0] = 12'h123;
`endif
    lookup(1, 0);
    wr_en = 1'b1; wr_level = 4'd13; wr_data = 12'h456;
    step();
    wr_en = 1'b0;
    drain();
    do_reset();
    lookup(1, 0);
    drain();

    // Flash L4, then count 8 frames out.
    pulse_flash(4, 0);
    lookup(4, 0);
    lookup(5, 0);
    lookup(4, 1);
    drain();
    for (int f = 0; f < 7; f++) frame();
    check_eq("flash_7frames", flash_active, 1'b1);
    frame();
    check_eq("flash_8frames", flash_active, 1'b0);
    lookup(4, 0);
    drain();

    // Restart in FLASH with a new level and simultaneous tick: count reloads.
    pulse_flash(4, 0);
    frame();
    frame();
    frame();
    pulse_flash(5, 1);
    lookup(5, 0);
    lookup(4, 0);
    drain();
    for (int f = 0; f < 7; f++) frame();
    check_eq("restart_7frames", flash_active, 1'b1);
    frame();
    check_eq("restart_8frames", flash_active, 1'b0);

    // Asynchronous reset mid-flash and mid-lookup.
    pulse_flash(6, 0);
    lookup(6, 0);
    #2 rst = 1'b1;
    exp_q.delete();
    m_active = 0;
    last_pix = '0;
    #1;
    check_eq("async_rst_flash", flash_active, 1'b0);
    check_eq("async_rst_valid", out_valid, 1'b0);
    check_eq("async_rst_pixel", pixel, 12'h000);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    lookup(6, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
